bigadd_arb: RTL and testbench

- Round-robin arbiter that shares one existing bigadd instance among NREQ requesters.
- bigadd is the 2-stage pipelined 64-bit adder.
- Accepts at most one add per clock and tags it with the requester index.
- Returns each sum with a one-hot valid to the requester that issued it.
- Sits between the GPS/RTC time-accumulation logic and the single shared adder.

---
 rtl/bigadd_arb_pkg.sv | 12 +
 rtl/bigadd.sv | 35 +++
 rtl/bigadd_arb_rr_pick.sv | 27 ++
 rtl/bigadd_arb.sv | 110 +++++++++++
 tb/tb_bigadd_arb.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/bigadd_arb_pkg.sv
// Shared constants and helpers for the bigadd arbiter slice.
package bigadd_arb_pkg;

   localparam int BIGADD_LATENCY = 2;
   localparam int OPW            = 64;

   // Tag width for a requester count; never narrower than one bit.
   function automatic int calc_lgnreq(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bigadd.sv
// Two-stage pipelined 64-bit adder: low half plus carry in stage 1, high half in stage 2.
// Holds no reset; validity is tracked by the caller.
module bigadd (
   input  logic        i_clk,
   input  logic        i_sync,
   input  logic [63:0] i_a,
   input  logic [63:0] i_b,
   output logic        o_sync,
   output logic [63:0] o_r
);

   logic [31:0] lo_q;
   logic        carry_q;
   logic [31:0] a_hi_q;
   logic [31:0] b_hi_q;
   logic        sync_q;
   logic [63:0] r_q;
   logic        sync_out_q;

   always_ff @(posedge i_clk) begin
      {carry_q, lo_q} <= {1'b0, i_a[31:0]} + {1'b0, i_b[31:0]};
      a_hi_q          <= i_a[63:32];
      b_hi_q          <= i_b[63:32];
      sync_q          <= i_sync;
   end

   always_ff @(posedge i_clk) begin
      r_q        <= {a_hi_q + b_hi_q + {31'd0, carry_q}, lo_q};
      sync_out_q <= sync_q;
   end

   assign o_r    = r_q;
   assign o_sync = sync_out_q;

endmodule

// File: rtl/bigadd_arb_rr_pick.sv
// Rotate-priority picker: the first set request after the pointer, wrapping, wins.
module bigadd_arb_rr_pick #(
   parameter int NREQ   = 4,
   parameter int LGNREQ = 2
) (
   input  logic [NREQ-1:0]   req_i,
   input  logic [LGNREQ-1:0] ptr_i,
   output logic              grant_valid_o,
   output logic [LGNREQ-1:0] grant_o
);

   always_comb begin
      int idx;
      idx           = 0;
      grant_valid_o = 1'b0;
      grant_o       = '0;
      // Walk farthest-first so the nearest requester after the pointer is written last.
      for (int off = NREQ; off >= 1; off--) begin
         idx = (int'(ptr_i) + off) % NREQ;
         if (req_i[idx]) begin
            grant_valid_o = 1'b1;
            grant_o       = LGNREQ'(idx);
         end
      end
   end

endmodule

// File: rtl/bigadd_arb.sv
// Round-robin front end sharing one bigadd among NREQ requesters.
// Results return tagged with a one-hot valid after a fixed three-cycle latency.
module bigadd_arb
   import bigadd_arb_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int LGNREQ = calc_lgnreq(NREQ)
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [NREQ-1:0]     i_stb,
   input  logic [OPW*NREQ-1:0] i_a,
   input  logic [OPW*NREQ-1:0] i_b,
   output logic [NREQ-1:0]     o_busy,
   output logic [NREQ-1:0]     o_valid,
   output logic [OPW-1:0]      o_r,
   output logic                o_idle
);

   logic                     pick_valid;
   logic [LGNREQ-1:0]        pick_idx;
   logic                     grant_valid;
   logic [NREQ-1:0][OPW-1:0] a_vec;
   logic [NREQ-1:0][OPW-1:0] b_vec;

   logic [OPW-1:0]    issue_a_q,   issue_a_d;
   logic [OPW-1:0]    issue_b_q,   issue_b_d;
   logic [LGNREQ-1:0] issue_tag_q, issue_tag_d;
   logic              issue_vld_q, issue_vld_d;
   logic [LGNREQ-1:0] ptr_q,       ptr_d;

   logic [BIGADD_LATENCY-1:0]              pipe_vld_q;
   logic [BIGADD_LATENCY-1:0][LGNREQ-1:0]  pipe_tag_q;
   logic                                   unused_sync;

   assign a_vec = i_a;
   assign b_vec = i_b;

   bigadd_arb_rr_pick #(
      .NREQ   (NREQ),
      .LGNREQ (LGNREQ)
   ) u_pick (
      .req_i         (i_stb),
      .ptr_i         (ptr_q),
      .grant_valid_o (pick_valid),
      .grant_o       (pick_idx)
   );

   // Nothing is granted while reset is held so every line reads busy.
   assign grant_valid = pick_valid & ~i_reset;

   always_comb begin
      issue_a_d   = issue_a_q;
      issue_b_d   = issue_b_q;
      issue_tag_d = issue_tag_q;
      issue_vld_d = grant_valid;
      ptr_d       = ptr_q;
      if (grant_valid) begin
         issue_a_d   = a_vec[pick_idx];
         issue_b_d   = b_vec[pick_idx];
         issue_tag_d = pick_idx;
         ptr_d       = pick_idx;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         issue_a_q   <= '0;
         issue_b_q   <= '0;
         issue_tag_q <= '0;
         issue_vld_q <= 1'b0;
         ptr_q       <= LGNREQ'(NREQ - 1);
         pipe_vld_q  <= '0;
         pipe_tag_q  <= '0;
      end else begin
         issue_a_q   <= issue_a_d;
         issue_b_q   <= issue_b_d;
         issue_tag_q <= issue_tag_d;
         issue_vld_q <= issue_vld_d;
         ptr_q       <= ptr_d;
         pipe_vld_q  <= {pipe_vld_q[BIGADD_LATENCY-2:0], issue_vld_q};
         pipe_tag_q  <= {pipe_tag_q[BIGADD_LATENCY-2:0], issue_tag_q};
      end
   end

   // The adder's own sync output is ignored: it has no reset, so pipe_vld_q masks stale data.
   bigadd u_add (
      .i_clk  (i_clk),
      .i_sync (issue_vld_q),
      .i_a    (issue_a_q),
      .i_b    (issue_b_q),
      .o_sync (unused_sync),
      .o_r    (o_r)
   );

   always_comb begin
      o_valid = '0;
      if (pipe_vld_q[BIGADD_LATENCY-1])
         o_valid[pipe_tag_q[BIGADD_LATENCY-1]] = 1'b1;
   end

   always_comb begin
      o_busy = '1;
      for (int k = 0; k < NREQ; k++)
         o_busy[k] = !(grant_valid && (pick_idx == LGNREQ'(k)));
   end

   assign o_idle = i_reset | (~|i_stb & ~issue_vld_q & ~|pipe_vld_q);

endmodule

// File: tb/tb_bigadd_arb.sv
// Scoreboard bench for bigadd_arb: a reference round-robin model predicts grants,
// expected sums are queued at acceptance and checked when the result is due.
module tb_bigadd_arb;

   localparam int NREQ = 4;
   localparam int LAT  = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [3:0]   stb = '0;
   logic [63:0]  a_arr [4];
   logic [63:0]  b_arr [4];
   logic [255:0] pa, pb;
   logic [3:0]   o_busy, o_valid;
   logic [63:0]  o_r;
   logic         o_idle;

   typedef struct {
      int          tag;
      logic [63:0] sum;
      int          cyc;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   logic       en = 1'b0;
   logic [3:0] acc = '0;
   logic [3:0] hold = '0;
   int         mptr = NREQ - 1;
   int         waitc [4];
   int         maxw = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      pa = '0;
      pb = '0;
      for (int k = 0; k < NREQ; k++) begin
         pa[k*64 +: 64] = a_arr[k];
         pb[k*64 +: 64] = b_arr[k];
      end
   end

   bigadd_arb #(.NREQ(NREQ)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .i_stb   (stb),
      .i_a     (pa),
      .i_b     (pb),
      .o_busy  (o_busy),
      .o_valid (o_valid),
      .o_r     (o_r),
      .o_idle  (o_idle)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int model_grant(input logic [3:0] r, input int p);
      for (int off = 1; off <= NREQ; off++)
         if (r[(p + off) % NREQ]) return (p + off) % NREQ;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (en) begin
         acc = '0;
         if (rst) begin
            chk("busy_in_reset", o_busy, 4'hF);
            chk("valid_in_reset", o_valid, 4'h0);
            chk("idle_in_reset", o_idle, 1'b1);
         end else begin
            int         g;
            logic [3:0] eb;
            logic [3:0] oh;
            exp_t       e;
            chk("idle", o_idle, (stb == 4'h0) && (sb.size() == 0));
            g  = model_grant(stb, mptr);
            eb = 4'hF;
            if (g >= 0) eb[g] = 1'b0;
            chk("busy", o_busy, eb);
            if (sb.size() > 0 && sb[0].cyc + LAT <= cyc) begin
               if (sb[0].cyc + LAT == cyc) begin
                  oh = 4'b0001 << sb[0].tag;
                  chk("valid", o_valid, oh);
                  chk("sum", o_r, sb[0].sum);
               end else begin
                  chk("latency", cyc - sb[0].cyc, LAT);
               end
               void'(sb.pop_front());
            end else begin
               chk("valid_quiet", o_valid, 4'h0);
            end
            acc = stb & ~o_busy;
            if (g >= 0) begin
               e.tag = g;
               e.sum = a_arr[g] + b_arr[g];
               e.cyc = cyc;
               sb.push_back(e);
               mptr = g;
            end
            for (int k = 0; k < NREQ; k++) begin
               if (hold[k]) begin
                  if (stb[k] && !acc[k]) waitc[k]++;
                  else waitc[k] = 0;
                  if (waitc[k] > maxw) maxw = waitc[k];
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
         if (acc[k]) begin
            if (hold[k]) begin
               a_arr[k] = {$urandom, $urandom};
               b_arr[k] = {$urandom, $urandom};
            end else begin
               stb[k] = 1'b0;
            end
         end
      end
      acc = '0;
   endtask

   task automatic post(input int k, input logic [63:0] a, input logic [63:0] b);
      a_arr[k] = a;
      b_arr[k] = b;
      stb[k]   = 1'b1;
   endtask

   initial begin
      for (int k = 0; k < NREQ; k++) begin
         a_arr[k] = '0;
         b_arr[k] = '0;
         waitc[k] = 0;
      end
      #2;
      rst = 1'b1;
      en  = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      repeat (2) step();

      // all four at once, grants expected 0,1,2,3 from the reset pointer
      for (int k = 0; k < NREQ; k++) post(k, 64'(k), 64'h10);
      repeat (8) step();

      // low-half carry must ripple into bit 32
      post(1, 64'h0000_0001_FFFF_FFFF, 64'h1);
      repeat (5) step();

      // carry out of bit 63 is discarded
      post(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2);
      repeat (5) step();

      repeat (40) begin
         for (int k = 0; k < NREQ; k++)
            if (!stb[k] && $urandom_range(0, 2) == 0)
               post(k, {$urandom, $urandom}, {$urandom, $urandom});
         step();
      end
      repeat (6) step();

      // two continuous requesters must alternate
      maxw = 0;
      for (int k = 0; k < NREQ; k++) waitc[k] = 0;
      hold = 4'b0101;
      post(0, {$urandom, $urandom}, {$urandom, $urandom});
      post(2, {$urandom, $urandom}, {$urandom, $urandom});
      repeat (10) step();
      hold = '0;
      repeat (6) step();
      chk("fair_max_wait", maxw, 1);

      // reset between acceptance and result: the in-flight sum must vanish
      post(1, {$urandom, $urandom}, {$urandom, $urandom});
      step();
      rst = 1'b1;
      sb.delete();
      mptr = NREQ - 1;
      step();
      rst = 1'b0;
      repeat (2) step();
      post(0, {$urandom, $urandom}, {$urandom, $urandom});
      repeat (5) step();

      // lone strobe on requester 3
      repeat (2) step();
      post(3, {$urandom, $urandom}, {$urandom, $urandom});
      repeat (5) step();

      for (int i = 0; i < 20 && (sb.size() > 0 || stb != 4'h0); i++) step();
      chk("drain", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
